// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl -- data-memory access controller for the MEM stage of a 64-bit
// in-order pipeline.
//
// The controller accepts one load or store from the EX/MEM register. It checks
// alignment. It then runs a single memory transaction with byte lanes and byte
// enables, and returns a sign- or zero-extended load result for MEM/WB. While a
// request is pending, the controller stalls the upstream pipeline registers.
// If an access is misaligned or the memory never answers, the controller raises
// a one-cycle error pulse instead.
//
// Parameters
//   TIMEOUT_CYC  maximum number of ACCESS cycles before a timeout error
//
// Ports
//   clk          pipeline clock, all state changes on the rising edge
//   rst          asynchronous, active-low reset
//   req_valid    MEM stage holds a load or store
//   req_we       1 = store, 0 = load
//   req_func3    RISC-V funct3 of the load/store
//   req_addr     byte address
//   req_wdata    right-aligned store data
//   stall        freezes IF/ID, ID/EX and EX/MEM while high
//   rdata        extended load result (held until the next completed load)
//   rdata_valid  one-cycle pulse, rdata carries a new load result
//   err          one-cycle error pulse
//   err_cause    0 = misaligned access, 1 = timeout
//   mem_req      memory request
//   mem_we       memory write enable
//   mem_addr     doubleword-aligned memory address
//   mem_wdata    lane-shifted store data
//   mem_wmask    byte enables
//   mem_ready    memory completes the access in this cycle
//   mem_rdata    memory read data, valid with mem_ready
// -----------------------------------------------------------------------------
module dmem_ctrl #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_func3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        stall,
  output logic [63:0] rdata,
  output logic        rdata_valid,
  output logic        err,
  output logic        err_cause,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2,
    ERR    = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    lat_func3;
  logic [2:0]    lat_off;

  // ---------------------------------------------------------------------------
  // Request decode (IDLE only)
  // ---------------------------------------------------------------------------
  logic        size_aligned;
  logic        func_illegal;
  logic        req_ok;
  logic [3:0]  req_nbytes;
  logic [7:0]  store_mask;
  logic [63:0] store_data;

  always_comb begin
    size_aligned = 1'b1;
    case (req_func3[1:0])
      2'b00:   size_aligned = 1'b1;
      2'b01:   size_aligned = ~req_addr[0];
      2'b10:   size_aligned = (req_addr[1:0] == 2'b00);
      default: size_aligned = (req_addr[2:0] == 3'b000);
    endcase
  end

  // Stores only have sb/sh/sw/sd. Load code 111 does not exist. Both are
  // reported on the misaligned error path, so nothing undefined reaches memory.
  assign func_illegal = req_we ? req_func3[2] : (req_func3 == 3'b111);
  assign req_ok       = size_aligned & ~func_illegal;

  assign req_nbytes = 4'd1 << req_func3[1:0];

  // Byte lane gi is enabled when it falls inside [offset, offset + size).
  // That range equals the base mask shifted left by addr[2:0]. For aligned
  // accesses the range never wraps past lane 7.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_mask
      assign store_mask[gi] = (4'(gi) >= {1'b0, req_addr[2:0]}) &&
                              (4'(gi) <  ({1'b0, req_addr[2:0]} + req_nbytes));
    end
  endgenerate

  assign store_data = req_wdata << {req_addr[2:0], 3'b000};

  // ---------------------------------------------------------------------------
  // Load data: move the addressed lane down to bit 0, then extend.
  // ---------------------------------------------------------------------------
  logic [63:0] load_shift;
  logic [63:0] load_data;

  assign load_shift = mem_rdata >> {lat_off, 3'b000};

  always_comb begin
    load_data = load_shift;
    case (lat_func3)
      3'b000:  load_data = {{56{load_shift[7]}},  load_shift[7:0]};
      3'b001:  load_data = {{48{load_shift[15]}}, load_shift[15:0]};
      3'b010:  load_data = {{32{load_shift[31]}}, load_shift[31:0]};
      3'b100:  load_data = {56'd0, load_shift[7:0]};
      3'b101:  load_data = {48'd0, load_shift[15:0]};
      3'b110:  load_data = {32'd0, load_shift[31:0]};
      default: load_data = load_shift;
    endcase
  end

  // Stall follows req_valid combinationally in IDLE. This lets the request
  // cycle itself freeze the pipeline. Gating with rst releases the pipeline
  // as soon as reset is asserted.
  assign stall = rst && ((state == IDLE) ? req_valid : (state == ACCESS));

  // ---------------------------------------------------------------------------
  // FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      cnt         <= '0;
      lat_func3   <= 3'b000;
      lat_off     <= 3'b000;
      rdata       <= 64'd0;
      rdata_valid <= 1'b0;
      err         <= 1'b0;
      err_cause   <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 64'd0;
      mem_wdata   <= 64'd0;
      mem_wmask   <= 8'h00;
    end else begin
      // Pulse outputs last exactly one cycle unless re-asserted below.
      rdata_valid <= 1'b0;
      err         <= 1'b0;

      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_ok) begin
              state     <= ACCESS;
              cnt       <= '0;
              lat_func3 <= req_func3;
              lat_off   <= req_addr[2:0];
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[63:3], 3'b000};
              mem_wdata <= store_data;
              mem_wmask <= req_we ? store_mask : 8'h00;
            end else begin
              state     <= ERR;
              err       <= 1'b1;
              err_cause <= 1'b0;
            end
          end
        end

        ACCESS: begin
          // A completion in the last allowed cycle wins over the timeout.
          if (mem_ready) begin
            state     <= RESP;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 8'h00;
            if (!mem_we) begin
              rdata       <= load_data;
              rdata_valid <= 1'b1;
            end
          end else if (cnt == CNT_LAST) begin
            state     <= ERR;
            err       <= 1'b1;
            err_cause <= 1'b1;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wmask <= 8'h00;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // The pipeline advances during RESP and ERR. The request still visible
        // on req_valid belongs to the finished access and must not be taken.
        RESP:    state <= IDLE;
        ERR:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  req_func3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        stall;
  logic [63:0] rdata;
  logic        rdata_valid;
  logic        err;
  logic        err_cause;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_ready;
  logic [63:0] mem_rdata;

  dmem_ctrl #(.TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_we(req_we), .req_func3(req_func3),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid),
    .err(err), .err_cause(err_cause),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: byte-lane arithmetic from the access rules
  // ---------------------------------------------------------------------------
  function automatic int nbytes(input logic [2:0] f);
    return 1 << f[1:0];
  endfunction

  function automatic bit model_legal(input bit we, input logic [2:0] f, input logic [63:0] a);
    if (we && f > 3'd3) return 1'b0;
    if (!we && f == 3'd7) return 1'b0;
    return (int'(a[2:0]) % nbytes(f)) == 0;
  endfunction

  function automatic logic [7:0] model_mask(input logic [2:0] f, input logic [63:0] a);
    logic [15:0] m;
    m = ((16'd1 << nbytes(f)) - 16'd1) << a[2:0];
    return m[7:0];
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] wd, input logic [63:0] a);
    logic [63:0] r;
    r = wd << (8 * int'(a[2:0]));
    return r;
  endfunction

  function automatic logic [63:0] model_load(input logic [2:0] f, input logic [63:0] a,
                                             input logic [63:0] mrd);
    logic [63:0] tmp;
    logic [63:0] keep;
    logic [63:0] v;
    int n;
    n   = nbytes(f);
    tmp = mrd >> (8 * int'(a[2:0]));
    if (n == 8) return tmp;
    keep = (64'd1 << (8 * n)) - 64'd1;
    v    = tmp & keep;
    if (!f[2] && tmp[8*n-1]) v = v | ~keep;
    return v;
  endfunction

  typedef struct packed {
    logic        stall;
    logic        mem_req;
    logic        mem_we;
    logic [7:0]  wmask;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        chk_wdata;
    logic        rv;
    logic [63:0] rdata;
    logic        err;
    logic        cause;
  } exp_t;

  exp_t        expq[$];
  logic [63:0] model_rdata = 64'd0;
  bit          model_on = 1'b0;

  function automatic exp_t idle_exp();
    exp_t e;
    e       = '0;
    e.rdata = model_rdata;
    return e;
  endfunction

  // Per-cycle compare against the model timeline
  always @(negedge clk) begin
    if (model_on && expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("stall", 64'(stall), 64'(e.stall));
      chk("mem_req", 64'(mem_req), 64'(e.mem_req));
      chk("mem_we", 64'(mem_we), 64'(e.mem_we));
      chk("mem_wmask", 64'(mem_wmask), 64'(e.wmask));
      chk("rdata_valid", 64'(rdata_valid), 64'(e.rv));
      chk("rdata", rdata, e.rdata);
      chk("err", 64'(err), 64'(e.err));
      if (e.err) chk("err_cause", 64'(err_cause), 64'(e.cause));
      if (e.mem_req) chk("mem_addr", mem_addr, e.addr);
      if (e.mem_req && e.chk_wdata) chk("mem_wdata", mem_wdata, e.wdata);
    end
  end

  // Event counters used by the directed literal checks
  int          n_stall = 0, n_req = 0, n_err = 0, n_rv = 0;
  logic        last_cause = 1'b0, last_we = 1'b0;
  logic [7:0]  last_wmask = 8'h00;
  logic [63:0] last_addr = 64'd0, last_wdata = 64'd0;

  always @(negedge clk) begin
    if (stall) n_stall++;
    if (rdata_valid) n_rv++;
    if (err) begin
      n_err++;
      last_cause = err_cause;
    end
    if (mem_req) begin
      n_req++;
      last_we    = mem_we;
      last_wmask = mem_wmask;
      last_addr  = mem_addr;
      last_wdata = mem_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_we    = 1'($urandom);
      req_func3 = 3'($urandom);
      req_addr  = {$urandom, $urandom};
      mem_ready = 1'($urandom);
      mem_rdata = {$urandom, $urandom};
      expq.push_back(idle_exp());
    end
  endtask

  // lat = ACCESS cycle (1-based) in which mem_ready is raised
  task automatic do_txn(input bit we, input logic [2:0] f, input logic [63:0] a,
                        input logic [63:0] wd, input int lat, input logic [63:0] rd);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f;
    req_addr  = a;
    req_wdata = wd;
    mem_ready = 1'($urandom);
    mem_rdata = {$urandom, $urandom};
    e = idle_exp();
    e.stall = 1'b1;
    expq.push_back(e);
    if (!model_legal(we, f, a)) begin
      @(posedge clk); #1;
      mem_ready = 1'($urandom);
      e = idle_exp();
      e.err   = 1'b1;
      e.cause = 1'b0;
      expq.push_back(e);
    end else begin
      n = (lat < T) ? lat : T;
      for (int i = 1; i <= n; i++) begin
        @(posedge clk); #1;
        mem_ready = (i == lat);
        mem_rdata = (i == lat) ? rd : {$urandom, $urandom};
        e = idle_exp();
        e.stall     = 1'b1;
        e.mem_req   = 1'b1;
        e.mem_we    = we;
        e.wmask     = we ? model_mask(f, a) : 8'h00;
        e.addr      = {a[63:3], 3'b000};
        e.wdata     = model_wdata(wd, a);
        e.chk_wdata = we;
        expq.push_back(e);
      end
      @(posedge clk); #1;
      mem_ready = 1'($urandom);
      mem_rdata = {$urandom, $urandom};
      e = idle_exp();
      if (lat <= T) begin
        if (!we) begin
          model_rdata = model_load(f, a, rd);
          e.rv    = 1'b1;
          e.rdata = model_rdata;
        end
      end else begin
        e.err   = 1'b1;
        e.cause = 1'b1;
      end
      expq.push_back(e);
    end
  endtask

  task automatic settle();
    idle_cycles(1);
    @(negedge clk); #1;
  endtask

  int s_stall, s_req, s_err, s_rv;
  task automatic snap();
    s_stall = n_stall; s_req = n_req; s_err = n_err; s_rv = n_rv;
  endtask

  initial begin
    rst = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b000;
    req_addr = 64'h1000; req_wdata = 64'd0;
    mem_ready = 1'b1; mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    #12;
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_rdata", rdata, 64'd0);
    chk("rst_rdata_valid", 64'(rdata_valid), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_err_cause", 64'(err_cause), 64'd0);
    chk("rst_mem_req", 64'(mem_req), 64'd0);
    chk("rst_mem_we", 64'(mem_we), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);
    chk("rst_mem_wmask", 64'(mem_wmask), 64'd0);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    model_on = 1'b1;

    // Hand-computed values that pin the model
    chk("model_lb", model_load(3'b000, 64'h1003, 64'h8000_0000), 64'hFFFF_FFFF_FFFF_FF80);
    chk("model_sh_mask", 64'(model_mask(3'b001, 64'h2006)), 64'hC0);
    chk("model_sh_wdata", model_wdata(64'h1234, 64'h2006), 64'h1234_0000_0000_0000);

    // lb at 0x1003, ready in first ACCESS cycle
    idle_cycles(1);
    snap();
    do_txn(1'b0, 3'b000, 64'h1003, 64'd0, 1, 64'h0000_0000_8000_0000);
    settle();
    chk("lb_stall_cycles", 64'(n_stall - s_stall), 64'd2);
    chk("lb_rv_count", 64'(n_rv - s_rv), 64'd1);
    chk("lb_rdata", rdata, 64'hFFFF_FFFF_FFFF_FF80);

    // lbu, same access
    do_txn(1'b0, 3'b100, 64'h1003, 64'd0, 1, 64'h0000_0000_8000_0000);
    settle();
    chk("lbu_rdata", rdata, 64'h0000_0000_0000_0080);

    // sh at 0x2006
    snap();
    do_txn(1'b1, 3'b001, 64'h2006, 64'h1234, 1, 64'd0);
    settle();
    chk("sh_addr", last_addr, 64'h2000);
    chk("sh_wmask", 64'(last_wmask), 64'hC0);
    chk("sh_wdata", last_wdata, 64'h1234_0000_0000_0000);
    chk("sh_we", 64'(last_we), 64'd1);
    chk("sh_no_rv", 64'(n_rv - s_rv), 64'd0);
    chk("sh_rdata_held", rdata, 64'h0000_0000_0000_0080);

    // misaligned lw
    snap();
    do_txn(1'b0, 3'b010, 64'h3002, 64'd0, 1, 64'd0);
    settle();
    chk("lw_mis_req", 64'(n_req - s_req), 64'd0);
    chk("lw_mis_err", 64'(n_err - s_err), 64'd1);
    chk("lw_mis_cause", 64'(last_cause), 64'd0);

    // ld timeout
    snap();
    do_txn(1'b0, 3'b011, 64'h5000, 64'd0, 100, 64'd0);
    settle();
    chk("ld_to_req_cycles", 64'(n_req - s_req), 64'd4);
    chk("ld_to_err", 64'(n_err - s_err), 64'd1);
    chk("ld_to_cause", 64'(last_cause), 64'd1);

    // Reset in the 2nd ACCESS cycle of a wait-3 load
    chk("queue_before_reset", 64'(expq.size()), 64'd0);
    model_on = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_we = 1'b0; req_func3 = 3'b011;
    req_addr = 64'h100; mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_mid_req_before", 64'(mem_req), 64'd1);
    chk("rst_mid_stall_before", 64'(stall), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_mid_req", 64'(mem_req), 64'd0);
    chk("rst_mid_stall", 64'(stall), 64'd0);
    chk("rst_mid_rdata", rdata, 64'd0);
    req_valid = 1'b0;
    snap();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_rdata = 64'd0;
    model_on = 1'b1;
    idle_cycles(3);
    do_txn(1'b1, 3'b011, 64'h40, {$urandom, $urandom}, 2, 64'd0);
    settle();
    chk("rst_after_no_rv", 64'(n_rv - s_rv), 64'd0);
    chk("rst_after_no_err", 64'(n_err - s_err), 64'd0);
    chk("sd_wmask", 64'(last_wmask), 64'hFF);
    chk("sd_req_cycles", 64'(n_req - s_req), 64'd2);

    // Randomized traffic
    for (int k = 0; k < 300; k++) begin
      bit          we;
      logic [2:0]  f;
      logic [2:0]  off;
      logic [63:0] base;
      we = 1'($urandom);
      if (we) f = ($urandom % 8 == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      else    f = 3'($urandom_range(0, 6));
      base = {$urandom, $urandom};
      off  = 3'($urandom);
      if ($urandom % 4 != 0) off = 3'(int'(off) & ~(nbytes(f) - 1));
      do_txn(we, f, {base[63:3], off}, {$urandom, $urandom},
             $urandom_range(1, 6), {$urandom, $urandom});
      idle_cycles($urandom_range(0, 2));
    end
    settle();
    chk("queue_drained", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with ports named clk and rst.
REQ-002 Parameter TIMEOUT_CYC, default 64, SHALL set the maximum ACCESS cycles allowed before a timeout error.
REQ-003 clk  in  1  pipeline clock; all state changes on its rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  the MEM stage holds a load or store.
REQ-006 req_we  in  1  1 = store, 0 = load.
REQ-007 req_func3  in  3  load codes: 000 lb, 001 lh, 010 lw, 011 ld, 100 lbu, 101 lhu, 110 lwu; store codes: 000 sb, 001 sh, 010 sw, 011 sd.
REQ-008 req_addr  in  64  byte address (EX/MEM result).
REQ-009 req_wdata  in  64  store data (EX/MEM data2), right-aligned.
REQ-010 stall  out  1  freezes the IF/ID, ID/EX and EX/MEM registers while high.
REQ-011 rdata  out  64  extended load result for the MEM/WB register.
REQ-012 rdata_valid  out  1  one-cycle pulse, load data present on rdata.
REQ-013 err  out  1  one-cycle error pulse.
REQ-014 err_cause  out  1  0 = misaligned access, 1 = timeout.
REQ-015 mem_req, mem_we  out  1 each  memory request and write enable.
REQ-016 mem_addr  out  64  {req_addr[63:3], 3'b000}.
REQ-017 mem_wdata  out  64  lane-shifted store data.
REQ-018 mem_wmask  out  8  byte enables.
REQ-019 mem_ready  in  1  memory completes the access in this cycle.
REQ-020 mem_rdata  in  64  read data, valid when mem_ready is high.

Function
REQ-021 FSM states SHALL be IDLE, ACCESS, RESP and ERR.
REQ-022 IDLE: stall = req_valid, combinationally.
  - Aligned request: latch address, we, func3 and wdata, then go to ACCESS.
  - Misaligned request: go to ERR.
REQ-023 Alignment rule: half needs addr[0]=0, word needs addr[1:0]=0, double needs addr[2:0]=0, byte is always aligned.
REQ-024 A store with func3 greater than 011 SHALL be treated as misaligned.
REQ-025 ACCESS outputs: mem_req=1, stall=1, and the mem_* outputs driven from the latched values, held stable until mem_ready is sampled high.
REQ-026 ACCESS to RESP on mem_ready=1; a load captures mem_rdata in that same cycle.
REQ-027 A cycle counter SHALL clear on entering ACCESS; when it reaches TIMEOUT_CYC-1 without mem_ready, go to ERR with err_cause=1.
REQ-028 RESP outputs: stall=0, and rdata_valid=1 for loads only; the next state is IDLE unconditionally, and req_valid is ignored in RESP.
REQ-029 ERR outputs: err=1, stall=0, no memory access; the next state is IDLE.
REQ-030 Misaligned entry into ERR SHALL set err_cause=0.
REQ-031 Store mask: base masks are sb 0x01, sh 0x03, sw 0x0F, sd 0xFF, each shifted left by addr[2:0] bytes.
REQ-032 Store data: mem_wdata = req_wdata << (8*addr[2:0]), truncated to 64 bits.
REQ-033 Load data: tmp = mem_rdata >> (8*addr[2:0]), then sign- or zero-extend per func3 to 64 bits.
REQ-034 rdata SHALL hold its value until the next completed load.
REQ-035 Best-case latency: request at cycle 0, mem_req in cycle 1, mem_ready in cycle 1, RESP in cycle 2, so stall is high for cycles 0-1.
REQ-036 mem_ready outside ACCESS SHALL be ignored.
REQ-037 mem_we SHALL be 0 and mem_wmask SHALL be 0x00 whenever mem_req is 0.

Reset
REQ-038 rst=0 SHALL immediately and asynchronously force IDLE and clear the counter.
REQ-039 Reset values: stall=0, rdata=0, rdata_valid=0, err=0, err_cause=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0x00.
REQ-040 Reset asserted during ACCESS SHALL drop mem_req in the same cycle, without waiting for a clock edge.
REQ-041 The outstanding transaction SHALL be discarded, with no rdata_valid and no err.

Verification
REQ-042 Aligned lb at addr 0x1003 with mem_rdata 0x0000_0000_8000_0000, mem_ready=1 first cycle -> stall high for 2 cycles, then rdata=0xFFFF_FFFF_FFFF_FF80 with rdata_valid pulsed.
REQ-043 Same access as lbu -> rdata=0x0000_0000_0000_0080.
REQ-044 sh at addr 0x2006 with wdata 0x1234 -> mem_addr=0x2000, mem_wmask=0xC0, mem_wdata=0x1234_0000_0000_0000, mem_we=1, and no rdata_valid.
REQ-045 lw at addr 0x3002 -> no mem_req; err=1 and err_cause=0 in the cycle after the request; stall drops.
REQ-046 ld with mem_ready held low and TIMEOUT_CYC=4 -> mem_req for 4 cycles, then err=1 and err_cause=1, then IDLE.
REQ-047 rst driven low in the 2nd ACCESS cycle of a wait-3 load -> mem_req and stall go 0 immediately; after rst returns high, no rdata_valid and no err; the next sd at 0x40 completes normally with wmask=0xFF.
